// File: rtl/lieat_exu_com_disp_pkg.sv
// Shared EXU definitions: datapath widths, infobus bit indices and the issue-entry layout.
package lieat_exu_com_disp_pkg;

  localparam int XLEN      = 32;
  localparam int INFOBUS_W = XLEN;

  // ALU infobus bit indices
  localparam int INFOBUS_ALU_ADD  = 0;
  localparam int INFOBUS_ALU_SUB  = 1;
  localparam int INFOBUS_ALU_AND  = 2;
  localparam int INFOBUS_ALU_OR   = 3;
  localparam int INFOBUS_ALU_XOR  = 4;
  localparam int INFOBUS_ALU_EBRK = 10;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [INFOBUS_W-1:0] infobus;
  } disp_ent_t;

  localparam int DISP_ENT_W = $bits(disp_ent_t);

endpackage

// File: rtl/lieat_gnrl_fifo2.sv
// Generic 2-entry FIFO with valid/ready on both sides; flush empties it and blocks input.
module lieat_gnrl_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign in_ready_o  = ~flush_i & ((cnt_q != 2'd2) | pop);
  assign push        = in_valid_i & in_ready_o;
  assign out_data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; the consumer only looks at it while out_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= in_data_i;
  end

endmodule

// File: rtl/lieat_exu_com_disp.sv
// EXU dispatch stage: 2-entry issue buffer to the ALU, halting after an EBREAK retires
// until the pipeline flushes.
module lieat_exu_com_disp
  import lieat_exu_com_disp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 disp_i_valid,
  output logic                 disp_i_ready,
  input  logic [XLEN-1:0]      disp_i_pc,
  input  logic [XLEN-1:0]      disp_i_imm,
  input  logic [XLEN-1:0]      disp_i_src1,
  input  logic [XLEN-1:0]      disp_i_src2,
  input  logic [INFOBUS_W-1:0] disp_i_infobus,
  input  logic                 disp_flush,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic [XLEN-1:0]      alu_pc,
  output logic [XLEN-1:0]      alu_imm,
  output logic [XLEN-1:0]      alu_src1,
  output logic [XLEN-1:0]      alu_src2,
  output logic [INFOBUS_W-1:0] alu_infobus,
  output logic                 disp_o_halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } disp_state_e;

  disp_state_e state_q, state_d;
  disp_ent_t   in_ent, head_ent;
  logic        run;
  logic        fifo_in_ready, fifo_out_valid;
  logic        pop;

  assign run = (state_q == ST_RUN);

  assign in_ent = '{pc: disp_i_pc, imm: disp_i_imm, src1: disp_i_src1,
                    src2: disp_i_src2, infobus: disp_i_infobus};

  // Gating both handshakes with run freezes the buffer while halted.
  lieat_gnrl_fifo2 #(.W(DISP_ENT_W)) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (disp_flush),
    .in_valid_i  (disp_i_valid & run),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (in_ent),
    .out_valid_o (fifo_out_valid),
    .out_ready_i (alu_ready & run),
    .out_data_o  (head_ent)
  );

  assign disp_i_ready = run & fifo_in_ready;
  assign alu_valid    = run & fifo_out_valid;
  assign pop          = alu_valid & alu_ready;

  // Zero the ALU side when idle so stale storage never shows a phantom EBREAK.
  assign alu_pc        = alu_valid ? head_ent.pc      : '0;
  assign alu_imm       = alu_valid ? head_ent.imm     : '0;
  assign alu_src1      = alu_valid ? head_ent.src1    : '0;
  assign alu_src2      = alu_valid ? head_ent.src2    : '0;
  assign alu_infobus   = alu_valid ? head_ent.infobus : '0;
  assign disp_o_halted = (state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    if (disp_flush) begin
      state_d = ST_RUN;
    end else if (run && pop && head_ent.infobus[INFOBUS_ALU_EBRK]) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_lieat_exu_com_disp.sv
// Scoreboard bench for lieat_exu_com_disp: stimulus queues expected ALU entries,
// a negedge monitor checks every presented entry and the zero-gating when idle.
module tb_lieat_exu_com_disp;
  import lieat_exu_com_disp_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 disp_i_valid;
  logic                 disp_i_ready;
  logic [XLEN-1:0]      disp_i_pc, disp_i_imm, disp_i_src1, disp_i_src2;
  logic [INFOBUS_W-1:0] disp_i_infobus;
  logic                 disp_flush;
  logic                 alu_valid;
  logic                 alu_ready;
  logic [XLEN-1:0]      alu_pc, alu_imm, alu_src1, alu_src2;
  logic [INFOBUS_W-1:0] alu_infobus;
  logic                 disp_o_halted;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  disp_ent_t exp_q[$];

  localparam logic [INFOBUS_W-1:0] IB_ADD  = INFOBUS_W'(1) << INFOBUS_ALU_ADD;
  localparam logic [INFOBUS_W-1:0] IB_SUB  = INFOBUS_W'(1) << INFOBUS_ALU_SUB;
  localparam logic [INFOBUS_W-1:0] IB_EBRK = INFOBUS_W'(1) << INFOBUS_ALU_EBRK;

  lieat_exu_com_disp dut (
    .clock          (clock),
    .reset          (reset),
    .disp_i_valid   (disp_i_valid),
    .disp_i_ready   (disp_i_ready),
    .disp_i_pc      (disp_i_pc),
    .disp_i_imm     (disp_i_imm),
    .disp_i_src1    (disp_i_src1),
    .disp_i_src2    (disp_i_src2),
    .disp_i_infobus (disp_i_infobus),
    .disp_flush     (disp_flush),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_pc         (alu_pc),
    .alu_imm        (alu_imm),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_infobus    (alu_infobus),
    .disp_o_halted  (disp_o_halted)
  );

  always #5 clock = ~clock;

  function automatic disp_ent_t mk(logic [31:0] pc, logic [31:0] imm, logic [31:0] s1,
                                   logic [31:0] s2, logic [INFOBUS_W-1:0] ib);
    mk = '{pc: pc, imm: imm, src1: s1, src2: s2, infobus: ib};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Drive one entry; it is accepted at the next edge (caller has checked ready).
  task automatic drive(disp_ent_t e);
    disp_i_valid   = 1'b1;
    disp_i_pc      = e.pc;
    disp_i_imm     = e.imm;
    disp_i_src1    = e.src1;
    disp_i_src2    = e.src2;
    disp_i_infobus = e.infobus;
    #1;
  endtask

  task automatic push_ok(string nm, disp_ent_t e);
    drive(e);
    chk({nm, "_ready"}, 64'(disp_i_ready), 64'd1);
    if (disp_i_ready) exp_q.push_back(e);
    cyc();
    disp_i_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: presented head must match the scoreboard; idle outputs must be zero.
  always @(negedge clock) begin
    if (mon_en) begin
      if (alu_valid) begin
        disp_ent_t act;
        act = mk(alu_pc, alu_imm, alu_src1, alu_src2, alu_infobus);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected: got pc=%0h with no entry expected", alu_pc);
        end else if (act !== exp_q[0]) begin
          failures++;
          $display("FAIL mon_entry: got %h expected %h", act, exp_q[0]);
        end
        if (alu_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        checks++;
        if ({alu_pc, alu_imm, alu_src1, alu_src2, alu_infobus} !== '0) begin
          failures++;
          $display("FAIL mon_idle_zero: got pc=%0h ib=%0h expected 0", alu_pc, alu_infobus);
        end
      end
    end
  end

  task automatic check_idle_reset(string nm);
    chk({nm, "_alu_valid"}, 64'(alu_valid), 64'd0);
    chk({nm, "_alu_pc"}, 64'(alu_pc), 64'd0);
    chk({nm, "_alu_infobus"}, 64'(alu_infobus), 64'd0);
    chk({nm, "_halted"}, 64'(disp_o_halted), 64'd0);
    chk({nm, "_ready"}, 64'(disp_i_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; disp_i_valid = 1'b0; disp_flush = 1'b0; alu_ready = 1'b0;
    disp_i_pc = '0; disp_i_imm = '0; disp_i_src1 = '0; disp_i_src2 = '0; disp_i_infobus = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check_idle_reset("rst");
    mon_en = 1'b1;

    // Single issue, one-cycle latency
    alu_ready = 1'b1;
    push_ok("single", mk(32'h8000_0000, 32'h0, 32'd5, 32'd7, IB_ADD));
    chk("single_latency", 64'(alu_valid), 64'd1);
    cyc();
    chk("single_after", 64'(alu_valid), 64'd0);

    // Backpressure: A, B fill the buffer, C waits
    alu_ready = 1'b0;
    push_ok("bp_a", mk(32'h100, 32'h1, 32'h11, 32'h12, IB_ADD));
    push_ok("bp_b", mk(32'h104, 32'h2, 32'h21, 32'h22, IB_SUB));
    drive(mk(32'h108, 32'h3, 32'h31, 32'h32, IB_ADD));
    chk("bp_full_ready", 64'(disp_i_ready), 64'd0);
    cyc(); cyc(); cyc();
    chk("bp_stall_ready", 64'(disp_i_ready), 64'd0);
    alu_ready = 1'b1;
    push_ok("bp_c", mk(32'h108, 32'h3, 32'h31, 32'h32, IB_ADD));
    drain("bp");

    // Full with simultaneous push/pop across pointer wrap
    alu_ready = 1'b0;
    push_ok("wr_d", mk(32'h200, 32'h0, 32'hd1, 32'hd2, IB_ADD));
    push_ok("wr_e", mk(32'h204, 32'h0, 32'he1, 32'he2, IB_SUB));
    alu_ready = 1'b1;
    push_ok("wr_f", mk(32'h208, 32'h0, 32'hf1, 32'hf2, IB_ADD));
    push_ok("wr_g", mk(32'h20c, 32'h0, 32'h71, 32'h72, IB_SUB));
    alu_ready = 1'b0;
    #1;
    chk("wr_still_full", 64'(disp_i_ready), 64'd0);
    alu_ready = 1'b1;
    drain("wr");

    // EBREAK halts; the ADD behind it stays hidden until flush discards it
    alu_ready = 1'b0;
    push_ok("eb_k", mk(32'h300, 32'h0, 32'h1, 32'h2, IB_EBRK));
    push_ok("eb_l", mk(32'h304, 32'h0, 32'h3, 32'h4, IB_ADD));
    alu_ready = 1'b1;
    cyc();
    drive(mk(32'h308, 32'h0, 32'h5, 32'h6, IB_ADD));
    chk("eb_halted", 64'(disp_o_halted), 64'd1);
    chk("eb_alu_valid", 64'(alu_valid), 64'd0);
    chk("eb_ready", 64'(disp_i_ready), 64'd0);
    cyc(); cyc();
    chk("eb_still_halted", 64'(disp_o_halted), 64'd1);
    chk("eb_queue_kept", 64'(exp_q.size()), 64'd1);
    disp_i_valid = 1'b0;
    disp_flush = 1'b1;
    cyc();
    exp_q.delete();
    disp_flush = 1'b0;
    #1;
    chk("eb_flush_halted", 64'(disp_o_halted), 64'd0);
    chk("eb_flush_alu_valid", 64'(alu_valid), 64'd0);
    chk("eb_flush_ready", 64'(disp_i_ready), 64'd1);

    // Flush at count=2 with a same-cycle push
    alu_ready = 1'b0;
    push_ok("fl_m", mk(32'h400, 32'h0, 32'h41, 32'h42, IB_ADD));
    push_ok("fl_n", mk(32'h404, 32'h0, 32'h43, 32'h44, IB_SUB));
    drive(mk(32'h408, 32'h0, 32'h45, 32'h46, IB_ADD));
    disp_flush = 1'b1;
    #1;
    chk("fl_push_rejected", 64'(disp_i_ready), 64'd0);
    cyc();
    exp_q.delete();
    disp_flush = 1'b0;
    disp_i_valid = 1'b0;
    #1;
    chk("fl_alu_valid", 64'(alu_valid), 64'd0);
    chk("fl_alu_src1", 64'(alu_src1), 64'd0);
    chk("fl_halted", 64'(disp_o_halted), 64'd0);
    alu_ready = 1'b1;
    cyc();
    chk("fl_no_ghost", 64'(alu_valid), 64'd0);

    // Reset while halted with two entries buffered
    alu_ready = 1'b0;
    push_ok("rm_p", mk(32'h500, 32'h0, 32'h51, 32'h52, IB_EBRK));
    push_ok("rm_q", mk(32'h504, 32'h0, 32'h53, 32'h54, IB_ADD));
    alu_ready = 1'b1;
    push_ok("rm_r", mk(32'h508, 32'h0, 32'h55, 32'h56, IB_SUB));
    chk("rm_halted", 64'(disp_o_halted), 64'd1);
    reset = 1'b1;
    cyc();
    exp_q.delete();
    reset = 1'b0;
    alu_ready = 1'b0;
    #1;
    check_idle_reset("rm");
    cyc();
    chk("rm_stays_empty", 64'(alu_valid), 64'd0);

    cyc();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
